// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width default, synchronizer depth
// and FSM state encoding used by both SPI master and slave.
package spi_pkg;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave bus: serial pins toward the master plus the parallel
// tx/rx side toward the host logic.
interface spi_slave_if #(
    parameter int DATA_W = spi_pkg::DATA_W
);

    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              mode;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_ready;
    logic              busy;

    modport slave (
        input  sclk, cs, mosi, mode, tx_data, tx_load,
        output miso, rx_data, rx_valid, tx_ready, busy
    );

    modport master (
        output sclk, cs, mosi, mode, tx_data, tx_load,
        input  miso, rx_data, rx_valid, tx_ready, busy
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for asynchronous inputs, with a
// per-bit reset value so idle levels survive reset.
module spi_sync #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter int           STAGES  = spi_pkg::SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++)
                ff[i] <= RST_VAL;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled serial port with a single-entry tx buffer,
// selectable sample/drive edge and back-to-back frame support.
module spi_slave #(
    parameter int DATA_W = spi_pkg::DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    import spi_pkg::*;

    localparam int CW = $clog2(DATA_W);

    logic [2:0]          raw;
    logic [2:0]          syn;
    logic                cs_s, sclk_s, mosi_s;
    logic                cs_q, sclk_q;
    logic [SYNC_STAGES-1:0] settle;
    logic                armed;
    state_t              state, state_n;
    logic                mode_q;
    logic [CW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   tx_sr, rx_sr, tx_buf, tx_next;
    logic                tx_ready, miso, rx_valid, rx_done;
    logic [DATA_W-1:0]   rx_data;
    logic                start, stop, sample, drive, last, consume;
    logic                cs_fall, cs_rise, sclk_rise, sclk_fall;

    assign raw = {bus.cs, bus.sclk, bus.mosi};

    spi_sync #(
        .W       (3),
        .RST_VAL (3'b100)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (syn)
    );

    assign cs_s   = syn[2];
    assign sclk_s = syn[1];
    assign mosi_s = syn[0];

    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    always_comb begin
        state_n = state;
        start   = 1'b0;
        stop    = 1'b0;
        sample  = 1'b0;
        drive   = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && cs_fall) begin
                    state_n = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    stop    = 1'b1;
                end else begin
                    sample = mode_q ? sclk_fall : sclk_rise;
                    drive  = mode_q ? sclk_rise : sclk_fall;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign last    = sample && (bit_cnt == '0);
    assign consume = start | last;
    assign tx_next = tx_ready ? '0 : tx_buf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A cs low seen straight out of reset is stale: only arm once the
    // synchronizer has flushed and cs has been observed high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            settle   <= '0;
            armed    <= 1'b0;
            mode_q   <= 1'b0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            tx_buf   <= '0;
            tx_ready <= 1'b1;
            miso     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            cs_q     <= cs_s;
            sclk_q   <= sclk_s;
            settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
            if (settle[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
            rx_done  <= last;
            rx_valid <= rx_done;
            if (rx_done)
                rx_data <= rx_sr;
            if (start) begin
                mode_q  <= bus.mode;
                bit_cnt <= CW'(DATA_W - 1);
                tx_sr   <= tx_next;
                miso    <= tx_next[DATA_W-1];
            end
            if (stop)
                miso <= 1'b0;
            if (sample) begin
                rx_sr   <= {rx_sr[DATA_W-2:0], mosi_s};
                bit_cnt <= last ? CW'(DATA_W - 1) : bit_cnt - 1'b1;
                if (last)
                    tx_sr <= tx_next;
            end
            if (drive)
                miso <= tx_sr[bit_cnt];
            if (bus.tx_load) begin
                tx_buf   <= bus.tx_data;
                tx_ready <= 1'b0;
            end else if (consume) begin
                tx_ready <= 1'b1;
            end
        end
    end

    assign bus.miso     = miso;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.tx_ready = tx_ready;
    assign bus.busy     = (state == SHIFT);

endmodule
